axis_burst_gate: RTL and testbench
==================================

# axis_burst_gate

Downstream stage between `rampgen` and the RFSoC DAC AXI-Stream input. It consumes the 256-bit ramp stream and forwards it to the DAC only inside programmable burst windows, with zero-filled beats outside them. It supports single-shot or repeated burst/gap patterns, generates TLAST on the final burst beat, and zero-fills and counts upstream underruns so DAC timing stays deterministic.

## Interface
- `DATA_WIDTH`, 256, stream width (16 samples × 16 bit)
- `CNT_WIDTH`, 32, width of burst/gap length counters
- `UR_WIDTH`, 16, width of underrun counter
- `M_AXIS_ACLK`  in  1  sole clock
- `M_AXIS_ARESETN`  in  1  reset, synchronous, active-low
- `start`  in  1  one-cycle pulse; begins burst sequence when idle
- `stop`  in  1  one-cycle pulse; aborts to idle
- `continuous`  in  1  1 = repeat burst/gap forever, 0 = single burst
- `burst_len`  in  CNT_WIDTH  beats per burst
- `gap_len`  in  CNT_WIDTH  zero beats between bursts
- `S_AXIS_TDATA`  in  DATA_WIDTH  ramp data from rampgen
- `S_AXIS_TVALID`  in  1  upstream valid
- `S_AXIS_TLAST`  in  1  ignored
- `S_AXIS_TREADY`  out  1  upstream ready
- `M_AXIS_TDATA`  out  DATA_WIDTH  data to DAC
- `M_AXIS_TSTRB`  out  DATA_WIDTH/8  constant all-ones
- `M_AXIS_TVALID`  out  1  output valid
- `M_AXIS_TLAST`  out  1  last beat of burst
- `M_AXIS_TREADY`  in  1  DAC ready
- `busy`  out  1  state ≠ IDLE
- `burst_done`  out  1  one-cycle pulse after final burst slot
- `underrun_count`  out  UR_WIDTH  saturating count of zero-filled burst slots

## Operation
- FSM states: IDLE, BURST, GAP. `remaining` counter of CNT_WIDTH.
- `advance` = !M_AXIS_TVALID || M_AXIS_TREADY. The output register loads only on `advance`.
- `S_AXIS_TREADY` = (state==BURST) && advance && !stop (combinational).
- On advance in BURST: if S_AXIS_TVALID, load S_AXIS_TDATA; else load zero and increment underrun_count (saturating at all-ones). Each advance consumes one burst slot either way. TLAST=1 iff remaining==1, else 0.
- On advance in IDLE/GAP: load zero, TLAST=0.
- IDLE: start && burst_len≠0 → BURST, remaining=burst_len. start with burst_len==0 is ignored.
- BURST, advance with remaining>1: remaining−1.
- BURST, advance with remaining==1: pulse burst_done next cycle, then:
  - continuous && gap_len≠0 → GAP, remaining=gap_len.
  - continuous && gap_len==0 → BURST, remaining=burst_len (back-to-back).
  - !continuous → IDLE.
- GAP, advance: remaining−1; at remaining==1 → BURST, remaining=burst_len.
- burst_len/gap_len are sampled only at start and at each reload. Mid-burst changes take effect at the next reload.
- start while busy is ignored.
- stop has priority over start and advance: state→IDLE on that edge, no S handshake that cycle, the output loads zero if advance, no TLAST, no burst_done.
- A !continuous → 1 transition mid-sequence is honoured at the end of the current burst.

## Timing
- Reset (ARESETN=0 at an edge): M_AXIS_TVALID=0, M_AXIS_TDATA=0, M_AXIS_TLAST=0, busy=0, burst_done=0, underrun_count=0, state=IDLE, remaining=0. M_AXIS_TSTRB is constant all-ones, including during reset.
- First edge after release: the zero beat loads and TVALID=1. TVALID then stays 1 until the next reset.
- Latency: a beat accepted at edge k appears on M_AXIS_TDATA from edge k to the next advance.
- start sampled at edge k: busy=1 after k. The first burst slot is taken at edge k+1 if advance.
- While M_AXIS_TREADY=0 with TVALID=1: TDATA/TLAST are held, S_AXIS_TREADY=0, counters are frozen.
- burst_done is high for exactly one cycle after the edge that loads the TLAST beat.
- Reset mid-burst: all state clears on that edge. An incomplete burst does not resume.

## Test plan
- Reset: ARESETN low 4 cycles, TREADY=1 → TVALID=0, TDATA=0, busy=0. One cycle after release → TVALID=1, TDATA=0.
- Single burst: burst_len=4, continuous=0, upstream counter data 1,2,3,… always valid, start pulse → exactly 4 S handshakes. Output is 1,2,3,4 with TLAST only on 4; burst_done one cycle; zeros afterwards; busy=0.
- Repeat: burst_len=3, gap_len=2, continuous=1 → output pattern D,D,D(last),0,0,D,D,D(last). S_AXIS_TREADY=0 during the gap. Then gap_len=0 → bursts back-to-back, TLAST every 3rd beat.
- Underrun: burst_len=8, S_AXIS_TVALID low for 2 cycles mid-burst → 2 zero beats inside the burst, underrun_count=2, burst still ends after 8 slots with TLAST.
- Backpressure: M_AXIS_TREADY low 3 cycles mid-burst → TDATA/TLAST stable, S_AXIS_TREADY=0, remaining unchanged; the burst completes with the correct beat count and data order.
- Abort/edge cases: stop on the 2nd beat of burst_len=6 → IDLE next edge, no TLAST, no burst_done. start with burst_len=0 → stays IDLE. start while busy → no effect.

Source files
------------

// File: rtl/axis_burst_gate.sv
// Burst gate between the ramp generator and the DAC AXI-Stream input.
// Forwards upstream beats only inside programmed burst windows and zero-fills everything else.
module axis_burst_gate #(
    parameter int DATA_WIDTH = 256,
    parameter int CNT_WIDTH  = 32,
    parameter int UR_WIDTH   = 16
) (
    input  logic                    M_AXIS_ACLK,
    input  logic                    M_AXIS_ARESETN,
    input  logic                    start,
    input  logic                    stop,
    input  logic                    continuous,
    input  logic [CNT_WIDTH-1:0]    burst_len,
    input  logic [CNT_WIDTH-1:0]    gap_len,
    input  logic [DATA_WIDTH-1:0]   S_AXIS_TDATA,
    input  logic                    S_AXIS_TVALID,
    input  logic                    S_AXIS_TLAST,
    output logic                    S_AXIS_TREADY,
    output logic [DATA_WIDTH-1:0]   M_AXIS_TDATA,
    output logic [DATA_WIDTH/8-1:0] M_AXIS_TSTRB,
    output logic                    M_AXIS_TVALID,
    output logic                    M_AXIS_TLAST,
    input  logic                    M_AXIS_TREADY,
    output logic                    busy,
    output logic                    burst_done,
    output logic [UR_WIDTH-1:0]     underrun_count
);

    typedef enum logic [1:0] {IDLE, BURST, GAP} state_t;

    state_t                  state_reg, state_next;
    logic [CNT_WIDTH-1:0]    remaining_reg, remaining_next;
    logic                    burst_done_reg, burst_done_next;
    logic [DATA_WIDTH-1:0]   tdata_reg, tdata_next;
    logic                    tlast_reg, tlast_next;
    logic                    tvalid_reg;
    logic [UR_WIDTH-1:0]     underrun_reg, underrun_next;

    logic advance;
    logic slot_take;
    logic last_slot;
    logic unused_tlast;

    // Upstream framing is meaningless here; bursts are framed by burst_len alone.
    assign unused_tlast = S_AXIS_TLAST;

    assign advance   = !tvalid_reg || M_AXIS_TREADY;
    assign slot_take = (state_reg == BURST) && advance && !stop;
    assign last_slot = (remaining_reg == CNT_WIDTH'(1));

    always_ff @(posedge M_AXIS_ACLK) begin
        if (!M_AXIS_ARESETN) begin
            state_reg      <= IDLE;
            remaining_reg  <= '0;
            burst_done_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            remaining_reg  <= remaining_next;
            burst_done_reg <= burst_done_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        remaining_next  = remaining_reg;
        burst_done_next = 1'b0;
        if (stop) begin
            state_next     = IDLE;
            remaining_next = '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start && burst_len != '0) begin
                        state_next     = BURST;
                        remaining_next = burst_len;
                    end
                end
                BURST: begin
                    if (advance) begin
                        if (last_slot) begin
                            burst_done_next = 1'b1;
                            if (continuous && gap_len != '0) begin
                                state_next     = GAP;
                                remaining_next = gap_len;
                            end else if (continuous && burst_len != '0) begin
                                state_next     = BURST;
                                remaining_next = burst_len;
                            end else begin
                                state_next     = IDLE;
                                remaining_next = '0;
                            end
                        end else begin
                            remaining_next = remaining_reg - CNT_WIDTH'(1);
                        end
                    end
                end
                GAP: begin
                    if (advance) begin
                        // A burst_len cleared during the gap ends the sequence rather than
                        // entering BURST with nothing to count down.
                        if (last_slot) begin
                            if (burst_len != '0) begin
                                state_next     = BURST;
                                remaining_next = burst_len;
                            end else begin
                                state_next     = IDLE;
                                remaining_next = '0;
                            end
                        end else begin
                            remaining_next = remaining_reg - CNT_WIDTH'(1);
                        end
                    end
                end
                default: begin
                    state_next     = IDLE;
                    remaining_next = '0;
                end
            endcase
        end
    end

    always_comb begin
        tdata_next    = tdata_reg;
        tlast_next    = tlast_reg;
        underrun_next = underrun_reg;
        if (advance) begin
            tdata_next = '0;
            tlast_next = 1'b0;
            if (slot_take) begin
                tlast_next = last_slot;
                if (S_AXIS_TVALID) begin
                    tdata_next = S_AXIS_TDATA;
                end else if (underrun_reg != '1) begin
                    underrun_next = underrun_reg + UR_WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge M_AXIS_ACLK) begin
        if (!M_AXIS_ARESETN) begin
            tdata_reg    <= '0;
            tlast_reg    <= 1'b0;
            tvalid_reg   <= 1'b0;
            underrun_reg <= '0;
        end else begin
            tdata_reg    <= tdata_next;
            tlast_reg    <= tlast_next;
            tvalid_reg   <= 1'b1;
            underrun_reg <= underrun_next;
        end
    end

    assign S_AXIS_TREADY  = slot_take;
    assign M_AXIS_TDATA   = tdata_reg;
    assign M_AXIS_TSTRB   = '1;
    assign M_AXIS_TVALID  = tvalid_reg;
    assign M_AXIS_TLAST   = tlast_reg;
    assign busy           = (state_reg != IDLE);
    assign burst_done     = burst_done_reg;
    assign underrun_count = underrun_reg;

endmodule

// File: tb/tb_axis_burst_gate.sv
// Directed bench for axis_burst_gate: burst framing, repeat/gap, underrun, backpressure and abort.
// Upstream is a counter source that advances on every S-side handshake.
module tb_axis_burst_gate;

    logic         clk = 1'b0;
    logic         aresetn = 1'b0;
    logic         start = 1'b0;
    logic         stop = 1'b0;
    logic         continuous = 1'b0;
    logic [31:0]  burst_len = '0;
    logic [31:0]  gap_len = '0;
    logic [255:0] s_tdata;
    logic         s_tvalid = 1'b0;
    logic         s_tlast = 1'b0;
    logic         s_tready;
    logic [255:0] m_tdata;
    logic [31:0]  m_tstrb;
    logic         m_tvalid;
    logic         m_tlast;
    logic         m_tready = 1'b1;
    logic         busy;
    logic         burst_done;
    logic [15:0]  underrun_count;

    logic [31:0]  src_cnt = 32'd1;
    int           hs_cnt = 0;
    int           n_checks = 0;
    int           n_pass = 0;

    always #5 clk = ~clk;

    assign s_tdata = {224'd0, src_cnt};

    always @(posedge clk) begin
        if (s_tvalid && s_tready) begin
            src_cnt <= src_cnt + 32'd1;
            hs_cnt  <= hs_cnt + 1;
        end
    end

    axis_burst_gate dut (
        .M_AXIS_ACLK    (clk),
        .M_AXIS_ARESETN (aresetn),
        .start          (start),
        .stop           (stop),
        .continuous     (continuous),
        .burst_len      (burst_len),
        .gap_len        (gap_len),
        .S_AXIS_TDATA   (s_tdata),
        .S_AXIS_TVALID  (s_tvalid),
        .S_AXIS_TLAST   (s_tlast),
        .S_AXIS_TREADY  (s_tready),
        .M_AXIS_TDATA   (m_tdata),
        .M_AXIS_TSTRB   (m_tstrb),
        .M_AXIS_TVALID  (m_tvalid),
        .M_AXIS_TLAST   (m_tlast),
        .M_AXIS_TREADY  (m_tready),
        .busy           (busy),
        .burst_done     (burst_done),
        .underrun_count (underrun_count)
    );

    task automatic test_reset;
        aresetn  = 1'b0;
        m_tready = 1'b1;
        repeat (4) @(negedge clk);
        n_checks++;
        if (m_tvalid !== 1'b0 || m_tdata !== 256'd0 || busy !== 1'b0)
            $display("FAIL reset_state: tvalid=%b tdata=%0h busy=%b, want 0/0/0", m_tvalid, m_tdata, busy);
        else n_pass++;
        n_checks++;
        if (underrun_count !== 16'd0 || burst_done !== 1'b0 || m_tstrb !== 32'hFFFF_FFFF)
            $display("FAIL reset_misc: ur=%0d bd=%b strb=%h, want 0/0/ffffffff", underrun_count, burst_done, m_tstrb);
        else n_pass++;
        aresetn = 1'b1;
        @(negedge clk);
        n_checks++;
        if (m_tvalid !== 1'b1 || m_tdata !== 256'd0 || m_tlast !== 1'b0)
            $display("FAIL reset_release: tvalid=%b tdata=%0h tlast=%b, want 1/0/0", m_tvalid, m_tdata, m_tlast);
        else n_pass++;
    endtask

    task automatic test_single_burst;
        int hs0;
        logic [31:0] exp;
        hs0 = hs_cnt;
        exp = src_cnt;
        s_tvalid = 1'b1; burst_len = 32'd4; continuous = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b1 || m_tdata !== 256'd0)
            $display("FAIL single_start: busy=%b tdata=%0h, want 1/0", busy, m_tdata);
        else n_pass++;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            n_checks++;
            if (m_tdata !== ((i <= 4) ? {224'd0, exp} : 256'd0) || m_tlast !== (i == 4) || burst_done !== (i == 4))
                $display("FAIL single_beat%0d: tdata=%0h tlast=%b bd=%b, want %0h/%b/%b", i, m_tdata, m_tlast,
                         burst_done, (i <= 4) ? exp : 32'd0, (i == 4), (i == 4));
            else n_pass++;
            if (i <= 4) exp = exp + 32'd1;
        end
        n_checks++;
        if (busy !== 1'b0 || hs_cnt - hs0 != 4)
            $display("FAIL single_end: busy=%b handshakes=%0d, want 0/4", busy, hs_cnt - hs0);
        else n_pass++;
    endtask

    task automatic test_repeat;
        logic [0:14] rp_d    = 15'b111001111111110;
        logic [0:14] rp_l    = 15'b001000010010010;
        logic [0:14] rp_rdy  = 15'b110011111111100;
        logic [0:14] rp_busy = 15'b111111111111100;
        logic [31:0] exp;
        exp = src_cnt;
        burst_len = 32'd3; gap_len = 32'd2; continuous = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 1; i <= 15; i++) begin
            @(negedge clk);
            n_checks++;
            if (m_tdata !== (rp_d[i-1] ? {224'd0, exp} : 256'd0) || m_tlast !== rp_l[i-1] ||
                burst_done !== rp_l[i-1] || s_tready !== rp_rdy[i-1] || busy !== rp_busy[i-1])
                $display("FAIL repeat_slot%0d: tdata=%0h tlast=%b bd=%b srdy=%b busy=%b, want %0h/%b/%b/%b/%b",
                         i, m_tdata, m_tlast, burst_done, s_tready, busy, rp_d[i-1] ? exp : 32'd0,
                         rp_l[i-1], rp_l[i-1], rp_rdy[i-1], rp_busy[i-1]);
            else n_pass++;
            if (rp_d[i-1]) exp = exp + 32'd1;
            if (i == 5) gap_len = 32'd0;
            if (i == 11) continuous = 1'b0;
        end
    endtask

    task automatic test_underrun;
        logic [0:8] ur_d = 9'b111001110;
        logic [0:8] ur_l = 9'b000000010;
        logic [31:0] exp;
        int hs0;
        hs0 = hs_cnt;
        exp = src_cnt;
        n_checks++;
        if (underrun_count !== 16'd0)
            $display("FAIL underrun_pre: count=%0d, want 0", underrun_count);
        else n_pass++;
        burst_len = 32'd8; continuous = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            n_checks++;
            if (m_tdata !== (ur_d[i-1] ? {224'd0, exp} : 256'd0) || m_tlast !== ur_l[i-1] || busy !== (i < 8))
                $display("FAIL underrun_slot%0d: tdata=%0h tlast=%b busy=%b, want %0h/%b/%b", i, m_tdata,
                         m_tlast, busy, ur_d[i-1] ? exp : 32'd0, ur_l[i-1], (i < 8));
            else n_pass++;
            if (ur_d[i-1]) exp = exp + 32'd1;
            if (i == 3) s_tvalid = 1'b0;
            if (i == 5) s_tvalid = 1'b1;
        end
        n_checks++;
        if (underrun_count !== 16'd2 || hs_cnt - hs0 != 6)
            $display("FAIL underrun_count: count=%0d handshakes=%0d, want 2/6", underrun_count, hs_cnt - hs0);
        else n_pass++;
    endtask

    task automatic test_backpressure;
        logic [0:8] bp_rdy = 9'b110001111;
        int bp_off [9] = '{0, 1, 1, 1, 1, 2, 3, 4, -1};
        logic [31:0] base;
        int hs0;
        hs0 = hs_cnt;
        base = src_cnt;
        burst_len = 32'd5; continuous = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int e = 1; e <= 9; e++) begin
            m_tready = bp_rdy[e-1];
            #1;
            if (!bp_rdy[e-1]) begin
                n_checks++;
                if (s_tready !== 1'b0)
                    $display("FAIL bp_sready%0d: s_tready=%b, want 0", e, s_tready);
                else n_pass++;
            end
            @(negedge clk);
            n_checks++;
            if (m_tdata !== ((bp_off[e-1] < 0) ? 256'd0 : {224'd0, base + 32'(bp_off[e-1])}) ||
                m_tlast !== (e == 8) || burst_done !== (e == 8))
                $display("FAIL bp_edge%0d: tdata=%0h tlast=%b bd=%b, want %0h/%b/%b", e, m_tdata, m_tlast,
                         burst_done, (bp_off[e-1] < 0) ? 32'd0 : base + 32'(bp_off[e-1]), (e == 8), (e == 8));
            else n_pass++;
        end
        m_tready = 1'b1;
        n_checks++;
        if (hs_cnt - hs0 != 5 || busy !== 1'b0)
            $display("FAIL bp_count: handshakes=%0d busy=%b, want 5/0", hs_cnt - hs0, busy);
        else n_pass++;
    endtask

    task automatic test_abort;
        logic [31:0] exp;
        int hs0;
        hs0 = hs_cnt;
        exp = src_cnt;
        burst_len = 32'd6; continuous = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        n_checks++;
        if (m_tdata !== {224'd0, exp} || busy !== 1'b1)
            $display("FAIL abort_first: tdata=%0h busy=%b, want %0h/1", m_tdata, busy, exp);
        else n_pass++;
        stop = 1'b1;
        #1;
        n_checks++;
        if (s_tready !== 1'b0)
            $display("FAIL abort_sready: s_tready=%b, want 0", s_tready);
        else n_pass++;
        @(negedge clk);
        stop = 1'b0;
        n_checks++;
        if (m_tdata !== 256'd0 || m_tlast !== 1'b0 || busy !== 1'b0 || burst_done !== 1'b0)
            $display("FAIL abort_stop: tdata=%0h tlast=%b busy=%b bd=%b, want 0/0/0/0", m_tdata, m_tlast, busy,
                     burst_done);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (burst_done !== 1'b0 || m_tdata !== 256'd0 || hs_cnt - hs0 != 1)
            $display("FAIL abort_after: bd=%b tdata=%0h handshakes=%0d, want 0/0/1", burst_done, m_tdata,
                     hs_cnt - hs0);
        else n_pass++;
    endtask

    task automatic test_edge_cases;
        logic [31:0] exp;
        int hs0;
        hs0 = hs_cnt;
        burst_len = 32'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b0)
            $display("FAIL zero_len_start: busy=%b, want 0", busy);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || hs_cnt != hs0)
            $display("FAIL zero_len_idle: busy=%b handshakes=%0d, want 0/0", busy, hs_cnt - hs0);
        else n_pass++;
        exp = src_cnt;
        burst_len = 32'd3; start = 1'b1;
        @(negedge clk);
        burst_len = 32'd5;
        @(negedge clk);
        start = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            n_checks++;
            if (m_tdata !== ((i <= 3) ? {224'd0, exp} : 256'd0) || m_tlast !== (i == 3) || busy !== (i < 3))
                $display("FAIL busy_start%0d: tdata=%0h tlast=%b busy=%b, want %0h/%b/%b", i, m_tdata, m_tlast,
                         busy, (i <= 3) ? exp : 32'd0, (i == 3), (i < 3));
            else n_pass++;
            if (i <= 3) exp = exp + 32'd1;
            @(negedge clk);
        end
        n_checks++;
        if (hs_cnt - hs0 != 3)
            $display("FAIL busy_start_count: handshakes=%0d, want 3", hs_cnt - hs0);
        else n_pass++;
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_single_burst();
        test_repeat();
        test_underrun();
        test_backpressure();
        test_abort();
        test_edge_cases();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
